oled_frame_sequencer: RTL
=========================

# oled_frame_sequencer

Controller that owns the byte-level I2C master driving the SSD1306 128×64 OLED. After reset it waits for panel power-up, then streams the fixed 25-byte init command list. It then services frame-refresh requests: it sets the column/page window and copies 1024 bytes from an external synchronous frame buffer to display RAM, one I2C transaction per byte. It sits between the application's frame buffer and the I2C master, and is the only source of `start`/`DCn`/`Data` for that master.

## Interface

- `POWERUP_WAIT`, 2400000: cycles idle after reset before the first transaction (100 ms at 24 MHz).
- `FRAME_BYTES`, 1024: data bytes per refresh; must equal 128×64/8 for this panel.

- `clk`  in  1  system clock, 24 MHz.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `i2c_start`  out  1  one-cycle pulse to the I2C master.
- `i2c_dcn`  out  1  0 = command byte, 1 = display data byte.
- `i2c_data`  out  8  byte to transmit.
- `i2c_busy`  in  1  I2C master busy.
- `frame_go`  in  1  single-cycle request for a full-frame refresh.
- `pix_addr`  out  10  frame-buffer read address.
- `pix_rd`  out  1  frame-buffer read strobe.
- `pix_data`  in  8  frame-buffer byte, valid the cycle after `pix_rd`.
- `ready`  out  1  init complete, no refresh active or pending.
- `frame_done`  out  1  one-cycle pulse after the last data byte completes.

## Operation

- Reset values: `i2c_start`=0, `i2c_dcn`=0, `i2c_data`=0x00, `pix_addr`=0, `pix_rd`=0, `ready`=0, `frame_done`=0. The pending flag and all counters are cleared.
- Top-level states: PWR_WAIT → INIT → (CLEAR) → IDLE ⇄ WINDOW → STREAM → IDLE.
- PWR_WAIT: counts `POWERUP_WAIT` cycles. It then also waits for `i2c_busy`=0, because the I2C master has no reset and may still be finishing a transfer when `rst_n` falls mid-transaction.
- INIT: sends these bytes in order, each with `i2c_dcn`=0: AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 DA 12 81 CF D9 F1 DB 40 A4 A6 AF.
- WINDOW: sends six command bytes (`i2c_dcn`=0): 21 00 7F 22 00 07.
- STREAM: for k = 0..FRAME_BYTES−1, in increasing order:
  - pulse `pix_rd` with `pix_addr`=k;
  - capture `pix_data` the next cycle;
  - send the captured byte with `i2c_dcn`=1.
- After the last byte: pulse `frame_done` for one cycle, then go to IDLE.
- Byte handshake (sub-states ISSUE / ACCEPT / DONE):
  - ISSUE: with `i2c_busy`=0, drive `i2c_dcn`/`i2c_data` and pulse `i2c_start` for exactly one cycle.
  - ACCEPT: wait for `i2c_busy`=1.
  - DONE: wait for `i2c_busy`=0, then move to the next byte.
  - `i2c_dcn`/`i2c_data` stay stable from the ISSUE cycle until `i2c_busy` falls.
- `frame_go` handling:
  - Sets a single pending flag in any state.
  - Further pulses while the flag is set are absorbed; at most one refresh is queued.
  - IDLE with the flag set: clear the flag and enter WINDOW.
  - `frame_go` arriving during STREAM queues exactly one more refresh.
- `ready` = (state == IDLE) && !pending.
- Byte counters: INIT uses 5 bits, WINDOW 3 bits, STREAM 10 bits. No wrap-around is permitted; each phase ends on its terminal count.

## Timing

- `frame_go` in IDLE → `i2c_start` (first WINDOW byte) 2 cycles later.
- Between bytes:
  - `i2c_busy` fall → next `i2c_start` after 1 cycle (command bytes);
  - `i2c_busy` fall → next `i2c_start` after 3 cycles (data bytes: read cycle + capture cycle).
- `i2c_start` is never asserted while `i2c_busy`=1 or in two consecutive cycles.
- `frame_done` is asserted the cycle after the final `i2c_busy` fall; `ready` rises in the same cycle unless a refresh is pending.
- `rst_n` low at any point: all outputs take their reset values asynchronously. Restart is from PWR_WAIT.

## Configuration

- `OLED_SEQ_CLEAR_EN` defined: after INIT, runs WINDOW and then sends FRAME_BYTES bytes of 0x00 (`i2c_dcn`=1, no `pix_rd`) before entering IDLE. No `frame_done` pulse is generated for this clear pass.
- Not defined: INIT goes directly to IDLE; the CLEAR state and its logic are absent.

## Test plan

- `POWERUP_WAIT`=16, BFM master with busy = 20 cycles:
  - no `i2c_start` before cycle 16;
  - then exactly 25 transactions matching the INIT list, all `dcn`=0;
  - `ready` rises afterwards.
- Single `frame_go` with buffer byte[k] = k[7:0]:
  - 6 command transactions 21 00 7F 22 00 07;
  - then 1024 transactions with `dcn`=1 and data 00,01,…,FF repeating;
  - one `frame_done` pulse.
- Three `frame_go` pulses during STREAM → exactly one extra refresh (2 total); 2 `frame_done` pulses.
- `frame_go` during INIT → refresh starts only after byte AF completes; `ready` stays 0 throughout.
- Drop `rst_n` mid-STREAM while the BFM is busy:
  - outputs go to reset values immediately;
  - after `POWERUP_WAIT`, the first `i2c_start` waits for busy to fall;
  - INIT replays from AE.
- Build with `OLED_SEQ_CLEAR_EN`: after INIT come 6 window commands plus 1024 × 0x00 data bytes, no `pix_rd` activity, then `ready`=1.

Source files
------------

// File: rtl/oled_frame_sequencer.sv
// SSD1306 sequencer: waits for panel power-up, streams the init list, then copies frames to display RAM.
// Build option OLED_SEQ_CLEAR_EN adds a zero-fill pass of display RAM between init and the first IDLE.
module oled_frame_sequencer #(
   parameter int POWERUP_WAIT = 2400000,
   parameter int FRAME_BYTES  = 1024
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       i2c_start,
   output logic       i2c_dcn,
   output logic [7:0] i2c_data,
   input  logic       i2c_busy,
   input  logic       frame_go,
   output logic [9:0] pix_addr,
   output logic       pix_rd,
   input  logic [7:0] pix_data,
   output logic       ready,
   output logic       frame_done
);

   // state    | meaning
   // PWR_WAIT | power-up timer, then wait for a stale transfer to drain
   // INIT     | 25 init command bytes
   // IDLE     | waiting for a refresh request
   // WINDOW   | column/page window commands
   // STREAM   | frame-buffer bytes to display RAM
   // CLEAR    | zero-fill of display RAM (OLED_SEQ_CLEAR_EN only)
   typedef enum logic [2:0] {
      S_PWR_WAIT = 3'd0,
      S_INIT     = 3'd1,
      S_IDLE     = 3'd2,
      S_WINDOW   = 3'd3,
      S_STREAM   = 3'd4
`ifdef OLED_SEQ_CLEAR_EN
      , S_CLEAR  = 3'd5
`endif
   } state_t;

   typedef enum logic [2:0] {
      PH_ISSUE   = 3'd0,
      PH_ACCEPT  = 3'd1,
      PH_DONE    = 3'd2,
      PH_READ    = 3'd3,
      PH_CAPTURE = 3'd4
   } phase_t;

   localparam int PW_W = (POWERUP_WAIT > 1) ? $clog2(POWERUP_WAIT) : 1;
   localparam logic [PW_W-1:0] PW_LOAD = PW_W'((POWERUP_WAIT > 0) ? POWERUP_WAIT - 1 : 0);
   localparam logic [4:0] INIT_LAST = 5'd24;
   localparam logic [2:0] WIN_LAST  = 3'd5;
   localparam logic [9:0] PIX_LAST  = 10'(FRAME_BYTES - 1);

   function automatic logic [7:0] init_byte(input logic [4:0] idx);
      logic [7:0] b;
      case (idx)
         5'd0:    b = 8'hAE;
         5'd1:    b = 8'hD5;
         5'd2:    b = 8'h80;
         5'd3:    b = 8'hA8;
         5'd4:    b = 8'h3F;
         5'd5:    b = 8'hD3;
         5'd6:    b = 8'h00;
         5'd7:    b = 8'h40;
         5'd8:    b = 8'h8D;
         5'd9:    b = 8'h14;
         5'd10:   b = 8'h20;
         5'd11:   b = 8'h00;
         5'd12:   b = 8'hA1;
         5'd13:   b = 8'hC8;
         5'd14:   b = 8'hDA;
         5'd15:   b = 8'h12;
         5'd16:   b = 8'h81;
         5'd17:   b = 8'hCF;
         5'd18:   b = 8'hD9;
         5'd19:   b = 8'hF1;
         5'd20:   b = 8'hDB;
         5'd21:   b = 8'h40;
         5'd22:   b = 8'hA4;
         5'd23:   b = 8'hA6;
         5'd24:   b = 8'hAF;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   function automatic logic [7:0] win_byte(input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = 8'h21;
         3'd1:    b = 8'h00;
         3'd2:    b = 8'h7F;
         3'd3:    b = 8'h22;
         3'd4:    b = 8'h00;
         3'd5:    b = 8'h07;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   state_t          state_q, state_d;
   phase_t          phase_q, phase_d;
   logic [PW_W-1:0] wait_q, wait_d;
   logic [4:0]      init_idx_q, init_idx_d;
   logic [2:0]      win_idx_q, win_idx_d;
   logic [9:0]      pix_idx_q, pix_idx_d;
   logic [7:0]      byte_q, byte_d;
   logic            dcn_q, dcn_d;
   logic            pending_q, pending_d;
   logic            frame_done_q, frame_done_d;
   logic            take;
   logic            byte_active;
   logic            byte_done;
`ifdef OLED_SEQ_CLEAR_EN
   logic            clear_pass_q, clear_pass_d;
`endif

   always_comb begin
      byte_active = (state_q == S_INIT) || (state_q == S_WINDOW) || (state_q == S_STREAM);
`ifdef OLED_SEQ_CLEAR_EN
      if (state_q == S_CLEAR) byte_active = 1'b1;
`endif
   end

   assign byte_done = byte_active && (phase_q == PH_DONE) && !i2c_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_PWR_WAIT;
         phase_q      <= PH_ISSUE;
         wait_q       <= PW_LOAD;
         init_idx_q   <= '0;
         win_idx_q    <= '0;
         pix_idx_q    <= '0;
         byte_q       <= '0;
         dcn_q        <= 1'b0;
         pending_q    <= 1'b0;
         frame_done_q <= 1'b0;
`ifdef OLED_SEQ_CLEAR_EN
         clear_pass_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         wait_q       <= wait_d;
         init_idx_q   <= init_idx_d;
         win_idx_q    <= win_idx_d;
         pix_idx_q    <= pix_idx_d;
         byte_q       <= byte_d;
         dcn_q        <= dcn_d;
         pending_q    <= pending_d;
         frame_done_q <= frame_done_d;
`ifdef OLED_SEQ_CLEAR_EN
         clear_pass_q <= clear_pass_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      wait_d       = wait_q;
      init_idx_d   = init_idx_q;
      win_idx_d    = win_idx_q;
      pix_idx_d    = pix_idx_q;
      byte_d       = byte_q;
      dcn_d        = dcn_q;
      frame_done_d = 1'b0;
      take         = 1'b0;
      i2c_start    = 1'b0;
      pix_rd       = 1'b0;
`ifdef OLED_SEQ_CLEAR_EN
      clear_pass_d = clear_pass_q;
`endif

      // Per-byte handshake shared by every byte-sending state; DONE exits are decided below.
      if (byte_active) begin
         case (phase_q)
            PH_ISSUE: begin
               if (!i2c_busy) begin
                  i2c_start = 1'b1;
                  phase_d   = PH_ACCEPT;
               end
            end
            PH_ACCEPT: if (i2c_busy) phase_d = PH_DONE;
            PH_DONE: ;
            PH_READ: begin
               pix_rd  = 1'b1;
               phase_d = PH_CAPTURE;
            end
            PH_CAPTURE: begin
               byte_d  = pix_data;
               dcn_d   = 1'b1;
               phase_d = PH_ISSUE;
            end
            default: phase_d = PH_ISSUE;
         endcase
      end

      case (state_q)
         S_PWR_WAIT: begin
            if (wait_q != '0) begin
               wait_d = wait_q - PW_W'(1);
            end else if (!i2c_busy) begin
               state_d    = S_INIT;
               phase_d    = PH_ISSUE;
               init_idx_d = '0;
               byte_d     = init_byte(5'd0);
               dcn_d      = 1'b0;
            end
         end
         S_INIT: begin
            if (byte_done) begin
               if (init_idx_q == INIT_LAST) begin
`ifdef OLED_SEQ_CLEAR_EN
                  clear_pass_d = 1'b1;
                  state_d      = S_WINDOW;
                  phase_d      = PH_ISSUE;
                  win_idx_d    = '0;
                  byte_d       = win_byte(3'd0);
                  dcn_d        = 1'b0;
`else
                  state_d = S_IDLE;
`endif
               end else begin
                  init_idx_d = init_idx_q + 5'd1;
                  byte_d     = init_byte(init_idx_q + 5'd1);
                  phase_d    = PH_ISSUE;
               end
            end
         end
         S_IDLE: begin
            if (pending_q) begin
               take      = 1'b1;
               state_d   = S_WINDOW;
               phase_d   = PH_ISSUE;
               win_idx_d = '0;
               byte_d    = win_byte(3'd0);
               dcn_d     = 1'b0;
            end
         end
         S_WINDOW: begin
            if (byte_done) begin
               if (win_idx_q == WIN_LAST) begin
                  pix_idx_d = '0;
`ifdef OLED_SEQ_CLEAR_EN
                  if (clear_pass_q) begin
                     state_d = S_CLEAR;
                     phase_d = PH_ISSUE;
                     byte_d  = 8'h00;
                     dcn_d   = 1'b1;
                  end else
`endif
                  begin
                     state_d = S_STREAM;
                     phase_d = PH_READ;
                  end
               end else begin
                  win_idx_d = win_idx_q + 3'd1;
                  byte_d    = win_byte(win_idx_q + 3'd1);
                  phase_d   = PH_ISSUE;
               end
            end
         end
         S_STREAM: begin
            if (byte_done) begin
               if (pix_idx_q == PIX_LAST) begin
                  state_d      = S_IDLE;
                  pix_idx_d    = '0;
                  frame_done_d = 1'b1;
               end else begin
                  pix_idx_d = pix_idx_q + 10'd1;
                  phase_d   = PH_READ;
               end
            end
         end
`ifdef OLED_SEQ_CLEAR_EN
         S_CLEAR: begin
            if (byte_done) begin
               if (pix_idx_q == PIX_LAST) begin
                  state_d      = S_IDLE;
                  pix_idx_d    = '0;
                  clear_pass_d = 1'b0;
               end else begin
                  pix_idx_d = pix_idx_q + 10'd1;
                  phase_d   = PH_ISSUE;
               end
            end
         end
`endif
         default: state_d = S_PWR_WAIT;
      endcase

      // Only one refresh can be queued; a request landing while one is queued is absorbed.
      pending_d = take ? 1'b0 : (pending_q | frame_go);
   end

   assign i2c_dcn    = dcn_q;
   assign i2c_data   = byte_q;
   assign pix_addr   = pix_idx_q;
   assign ready      = (state_q == S_IDLE) && !pending_q;
   assign frame_done = frame_done_q;

endmodule
